// File: rtl/bram_accessor_pkg.sv
// Shared definitions for the BRAM accessor blocks: FSM state encoding and
// default geometry of the shared BRAM.
package bram_accessor_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/counter_write.sv
// Word counter for the write side of the BRAM accessor.
// Clear wins over enable so a frame start always begins from zero.
module counter_write #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o <= '0;
        end else if (clr) begin
            cnt_o <= '0;
        end else if (en) begin
            cnt_o <= cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bram_write_ctrl.sv
// Write-side BRAM accessor: stores one frame of words from a valid/ready
// stream at addresses 0..len-1 and pulses done_o when the frame is in BRAM.
module bram_write_ctrl
    import bram_accessor_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_wdata_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH:0]   wr_cnt_o,
    output logic                  done_o
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    state_t          state;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   len_clamped;
    logic            hs;
    logic            start_acc;
    logic            clr;
    logic            last_word;

    assign s_ready_o   = (state == ST_WRITE);
    assign busy_o      = (state != ST_IDLE);
    assign hs          = s_valid_i & s_ready_o;
    assign start_acc   = (state == ST_IDLE) & start_i;
    assign clr         = start_acc | (state == ST_DONE);
    assign len_clamped = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign last_word   = (cnt == (len_q - LW'(1)));

    counter_write #(
        .CNT_WIDTH(LW)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hs),
        .clr   (clr),
        .cnt_o (cnt)
    );

    // wr_cnt_o trails the counter by one clear so the final count is still
    // visible while done_o is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            bram_en_o    <= 1'b0;
            bram_we_o    <= 1'b0;
            bram_addr_o  <= '0;
            bram_wdata_o <= '0;
            wr_cnt_o     <= '0;
            done_o       <= 1'b0;
        end else begin
            bram_en_o <= 1'b0;
            bram_we_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wr_cnt_o <= '0;
                    if (start_i) begin
                        len_q <= len_clamped;
                        state <= (len_clamped == '0) ? ST_DONE : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (hs) begin
                        bram_en_o    <= 1'b1;
                        bram_we_o    <= 1'b1;
                        bram_addr_o  <= cnt[ADDR_WIDTH-1:0];
                        bram_wdata_o <= s_data_i;
                        wr_cnt_o     <= cnt + LW'(1);
                        if (last_word) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_write_ctrl.sv
// Self-checking bench for bram_write_ctrl: a per-cycle vector table, directed
// multi-cycle sequences and randomized frames checked against a frame model.
module tb_bram_write_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_ready_o;
    logic          bram_en_o;
    logic          bram_we_o;
    logic [AW-1:0] bram_addr_o;
    logic [DW-1:0] bram_wdata_o;
    logic          busy_o;
    logic [AW:0]   wr_cnt_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic hs_prev = 1'b0;

    logic [AW-1:0] wlog_addr[$];
    logic [DW-1:0] wlog_data[$];
    int            done_cyc[$];
    logic [AW:0]   done_cnt[$];

    typedef struct {
        logic          start;
        logic [AW:0]   len;
        logic          valid;
        logic [DW-1:0] data;
        logic          ready;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          busy;
        logic [AW:0]   cnt;
        logic          done;
    } vec_t;

    vec_t vecs[14];

    bram_write_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .len_i        (len_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .bram_en_o    (bram_en_o),
        .bram_we_o    (bram_we_o),
        .bram_addr_o  (bram_addr_o),
        .bram_wdata_o (bram_wdata_o),
        .busy_o       (busy_o),
        .wr_cnt_o     (wr_cnt_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [AW:0] ln, input logic v, input logic [DW-1:0] d);
        start_i   = st;
        len_i     = ln;
        s_valid_i = v;
        s_data_i  = d;
    endtask

    function automatic vec_t mkVec(input logic st, input int ln, input logic v, input logic [DW-1:0] d,
                                   input logic rdy, input logic en, input logic we, input int addr,
                                   input logic [DW-1:0] wd, input logic busy, input int cnt, input logic done);
        vec_t r;
        r.start = st;  r.len = (AW+1)'(ln); r.valid = v;  r.data = d;
        r.ready = rdy; r.en = en;           r.we = we;     r.addr = AW'(addr);
        r.wdata = wd;  r.busy = busy;       r.cnt = (AW+1)'(cnt); r.done = done;
        return r;
    endfunction

    // Every BRAM strobe must follow a handshake by exactly one cycle; the
    // write and done logs feed the per-frame scoreboard.
    always @(negedge clk) begin
        if (mon_en) checkOutput("strobe_follows_hs", {62'd0, bram_en_o, bram_we_o}, {62'd0, hs_prev, hs_prev});
        hs_prev = s_valid_i & s_ready_o;
        if (bram_we_o) begin
            wlog_addr.push_back(bram_addr_o);
            wlog_data.push_back(bram_wdata_o);
        end
        if (done_o) begin
            done_cyc.push_back(cyc);
            done_cnt.push_back(wr_cnt_o);
        end
    end

    task automatic clearLogs();
        wlog_addr.delete();
        wlog_data.delete();
        done_cyc.delete();
        done_cnt.delete();
    endtask

    // Frame model: n = min(len, DEPTH) words land at addresses 0..n-1 in
    // handshake order, then one done_o two cycles after the last handshake.
    task automatic runFrame(input int len, input logic [31:0] pat, input int pat_len, input bit rnd, input bit noise);
        int n, idx, t, hs_cyc, start_cyc, d;
        logic v;
        logic [DW-1:0] exp_data[$];
        n = (len > DEPTH) ? DEPTH : len;
        clearLogs();
        @(posedge clk); #1;
        applyStimulus(1'b1, (AW+1)'(len), 1'b0, '0);
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        idx = 0; t = 0; hs_cyc = start_cyc;
        while (idx < n && t < 3000) begin
            if (rnd) v = 1'($urandom_range(0, 1));
            else     v = (t < pat_len) ? pat[t] : 1'b1;
            applyStimulus(noise && ($urandom_range(0, 3) == 0), (AW+1)'($urandom_range(0, 255)), v, $urandom);
            @(negedge clk);
            if (s_valid_i && s_ready_o) begin
                exp_data.push_back(s_data_i);
                hs_cyc = cyc;
                idx++;
            end
            @(posedge clk); #1;
            t++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        if (idx < n) checkOutput("frame_accept_timeout", 64'(idx), 64'(n));
        d = 0;
        while (done_cyc.size() == 0 && d < 10) begin
            @(posedge clk);
            d++;
        end
        repeat (3) @(posedge clk);
        checkOutput("write_count", 64'(wlog_addr.size()), 64'(n));
        for (int i = 0; i < wlog_addr.size() && i < n; i++) begin
            checkOutput("write_addr", 64'(wlog_addr[i]), 64'(i));
            checkOutput("write_data", 64'(wlog_data[i]), 64'(exp_data[i]));
        end
        checkOutput("done_count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) begin
            checkOutput("done_latency", 64'(done_cyc[0] - hs_cyc), 64'd2);
            checkOutput("done_wr_cnt", 64'(done_cnt[0]), 64'(n));
        end
    endtask

    initial begin
        int k, t, len;
        bit got;

        vecs[0]  = mkVec(1, 4, 0, 32'h0,  0, 0, 0, 0, 32'h0,  0, 0, 0);
        vecs[1]  = mkVec(0, 0, 1, 32'hA0, 1, 0, 0, 0, 32'h0,  1, 0, 0);
        vecs[2]  = mkVec(0, 0, 1, 32'hA1, 1, 1, 1, 0, 32'hA0, 1, 1, 0);
        vecs[3]  = mkVec(0, 0, 1, 32'hA2, 1, 1, 1, 1, 32'hA1, 1, 2, 0);
        vecs[4]  = mkVec(0, 0, 1, 32'hA3, 1, 1, 1, 2, 32'hA2, 1, 3, 0);
        vecs[5]  = mkVec(0, 0, 0, 32'h0,  0, 1, 1, 3, 32'hA3, 1, 4, 0);
        vecs[6]  = mkVec(1, 0, 0, 32'h0,  0, 0, 0, 3, 32'hA3, 0, 4, 1);
        vecs[7]  = mkVec(0, 0, 0, 32'h0,  0, 0, 0, 3, 32'hA3, 1, 0, 0);
        vecs[8]  = mkVec(0, 0, 0, 32'h0,  0, 0, 0, 3, 32'hA3, 0, 0, 1);
        vecs[9]  = mkVec(1, 1, 1, 32'hB0, 0, 0, 0, 3, 32'hA3, 0, 0, 0);
        vecs[10] = mkVec(0, 0, 1, 32'hB1, 1, 0, 0, 3, 32'hA3, 1, 0, 0);
        vecs[11] = mkVec(0, 0, 0, 32'h0,  0, 1, 1, 0, 32'hB1, 1, 1, 0);
        vecs[12] = mkVec(0, 0, 0, 32'h0,  0, 0, 0, 0, 32'hB1, 0, 1, 1);
        vecs[13] = mkVec(0, 0, 0, 32'h0,  0, 0, 0, 0, 32'hB1, 0, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 64'(s_ready_o), 64'd0);
        checkOutput("reset_we", {62'd0, bram_en_o, bram_we_o}, 64'd0);
        checkOutput("reset_addr_data", {25'd0, bram_addr_o, bram_wdata_o}, 64'd0);
        checkOutput("reset_busy_cnt_done", {54'd0, busy_o, wr_cnt_o, done_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        $display("[TB] vector table");
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].start, vecs[i].len, vecs[i].valid, vecs[i].data);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ready", i), 64'(s_ready_o), 64'(vecs[i].ready));
            checkOutput($sformatf("vec%0d_en", i), 64'(bram_en_o), 64'(vecs[i].en));
            checkOutput($sformatf("vec%0d_we", i), 64'(bram_we_o), 64'(vecs[i].we));
            checkOutput($sformatf("vec%0d_addr", i), 64'(bram_addr_o), 64'(vecs[i].addr));
            checkOutput($sformatf("vec%0d_wdata", i), 64'(bram_wdata_o), 64'(vecs[i].wdata));
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vecs[i].busy));
            checkOutput($sformatf("vec%0d_wr_cnt", i), 64'(wr_cnt_o), 64'(vecs[i].cnt));
            checkOutput($sformatf("vec%0d_done", i), 64'(done_o), 64'(vecs[i].done));
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, '0, 1'b0, '0);

        $display("[TB] len=3 with gapped valid");
        runFrame(3, 32'b101001, 6, 1'b0, 1'b0);
        $display("[TB] len=0");
        runFrame(0, 32'd0, 0, 1'b0, 1'b0);
        $display("[TB] len=200 clamped, start pulses during WRITE");
        runFrame(200, 32'd0, 0, 1'b0, 1'b1);

        $display("[TB] reset mid-frame");
        clearLogs();
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'd5, 1'b0, '0);
        @(posedge clk); #1;
        k = 0; t = 0;
        while (k < 2 && t < 20) begin
            applyStimulus(1'b0, '0, 1'b1, 32'hE0 + 32'(k));
            @(negedge clk);
            if (s_valid_i && s_ready_o) k++;
            @(posedge clk); #1;
            t++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        if (k < 2) checkOutput("rst_frame_timeout", 64'(k), 64'd2);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", 64'(s_ready_o), 64'd0);
        checkOutput("midrst_en_we", {62'd0, bram_en_o, bram_we_o}, 64'd0);
        checkOutput("midrst_addr", 64'(bram_addr_o), 64'd0);
        checkOutput("midrst_wdata", 64'(bram_wdata_o), 64'd0);
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_wr_cnt", 64'(wr_cnt_o), 64'd0);
        checkOutput("midrst_done", 64'(done_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        checkOutput("midrst_no_done", 64'(done_cyc.size()), 64'd0);
        @(negedge clk);
        mon_en = 1'b1;
        runFrame(2, 32'd0, 0, 1'b0, 1'b0);

        $display("[TB] back-to-back frames");
        clearLogs();
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'd3, 1'b0, '0);
        @(posedge clk); #1;
        k = 0; t = 0; got = 1'b0;
        while (!got && t < 50) begin
            applyStimulus(1'b0, '0, (k < 3), 32'hC0 + 32'(k));
            @(negedge clk);
            if (s_valid_i && s_ready_o) k++;
            if (done_o) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
            t++;
        end
        if (!got) checkOutput("b2b_first_done_timeout", 64'd0, 64'd1);
        applyStimulus(1'b1, 8'd2, 1'b0, '0);
        @(posedge clk); #1;
        k = 0; t = 0;
        while (k < 2 && t < 50) begin
            applyStimulus(1'b0, '0, 1'b1, 32'hD0 + 32'(k));
            @(negedge clk);
            if (s_valid_i && s_ready_o) k++;
            @(posedge clk); #1;
            t++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        repeat (6) @(posedge clk);
        checkOutput("b2b_write_count", 64'(wlog_addr.size()), 64'd5);
        for (int i = 0; i < wlog_addr.size() && i < 5; i++) begin
            checkOutput("b2b_addr", 64'(wlog_addr[i]), (i < 3) ? 64'(i) : 64'(i - 3));
            checkOutput("b2b_data", 64'(wlog_data[i]), (i < 3) ? 64'(32'hC0 + i) : 64'(32'hD0 + i - 3));
        end
        checkOutput("b2b_done_count", 64'(done_cyc.size()), 64'd2);
        if (done_cyc.size() == 2) checkOutput("b2b_done_spacing", 64'(done_cyc[1] - done_cyc[0]), 64'd4);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(129, 255)) : int'($urandom_range(0, 40));
            runFrame(len, 32'd0, 0, 1'b1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_write_ctrl.md
Name: bram_write_ctrl

Overview:
- Write-side BRAM accessor; the counterpart of the read-side address counter in bram_accessor.
- Accepts a frame of len_i words on a valid/ready input stream. Writes them to consecutive BRAM addresses starting at 0.
- Pulses done_o once the last word has been written, so the read side can begin.
- Sits between the upstream producer and the single write port of the shared BRAM.

Parameters:
- ADDR_WIDTH, 7, BRAM address width.
- DATA_WIDTH, 32, BRAM word width.
- DEPTH, 128, BRAM words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle frame start; sampled only in IDLE.
- len_i  input  ADDR_WIDTH+1  frame length in words, sampled with start_i.
- s_valid_i  input  1  input word valid.
- s_data_i  input  DATA_WIDTH  input word.
- s_ready_o  output  1  block accepts a word this cycle.
- bram_en_o  output  1  BRAM port enable, registered.
- bram_we_o  output  1  BRAM write enable, registered.
- bram_addr_o  output  ADDR_WIDTH  BRAM address, registered.
- bram_wdata_o  output  DATA_WIDTH  BRAM write data, registered.
- busy_o  output  1  high in WRITE and DONE.
- wr_cnt_o  output  ADDR_WIDTH+1  words written in the current frame.
- done_o  output  1  one-cycle frame-complete pulse, registered.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs become 0: s_ready_o, bram_en_o, bram_we_o, bram_addr_o, bram_wdata_o, busy_o, wr_cnt_o, done_o.
  - Address counter and latched length clear.
  - Reset asserted mid-frame abandons the frame with no done_o. Words already written stay in the BRAM.
- States: IDLE, WRITE, DONE. Encoding is local.
- IDLE:
  - s_ready_o=0.
  - On start_i=1:
    - Latch len = min(len_i, DEPTH) and clear the counter.
    - If len ≠ 0, go to WRITE.
    - If len = 0, go to DONE with no BRAM writes.
- WRITE:
  - s_ready_o=1, combinational from the state.
  - A handshake is s_valid_i & s_ready_o at a rising edge.
  - On a handshake at edge k:
    - In cycle k+1: bram_en_o=1, bram_we_o=1, bram_addr_o=cnt, bram_wdata_o=s_data_i.
    - cnt increments.
  - If the handshake occurs with cnt == len-1, go to DONE.
  - With no handshake: bram_en_o=0 and bram_we_o=0 next cycle; bram_addr_o and bram_wdata_o hold their values.
  - s_valid_i low for any number of cycles stalls without loss.
- DONE:
  - Lasts one cycle; s_ready_o=0; counter clears; next state is IDLE.
  - done_o=1 in the cycle after DONE, which is also the cycle after the final bram_we_o.
  - done_o is always exactly one cycle wide.
- Latency:
  - Handshake to BRAM strobe: 1 cycle.
  - Final handshake to done_o: 2 cycles.
- start_i:
  - Ignored in WRITE and DONE.
  - Accepted in the same cycle done_o is high, since the FSM is already in IDLE; back-to-back frames are legal.
- wr_cnt_o:
  - Equals cnt in WRITE.
  - Holds the final count during DONE and while done_o is high.
  - Returns to 0 in the IDLE cycle after done_o.
- Width rules:
  - cnt is ADDR_WIDTH+1 bits.
  - bram_addr_o is cnt[ADDR_WIDTH-1:0].
  - With len clamped to DEPTH, the address never wraps within a frame.
- Simultaneous s_valid_i and start_i in IDLE: the word is not accepted, because s_ready_o=0.

Decomposition:
- Shared package bram_accessor_pkg:
  - state encoding constants ST_IDLE, ST_WRITE, ST_DONE;
  - default ADDR_WIDTH, DATA_WIDTH, DEPTH.
- Sub-module counter_write, parameter CNT_WIDTH=ADDR_WIDTH+1:
  - inputs clk, rst_n, en (handshake), clr (DONE or start);
  - output cnt_o;
  - clr has priority over en.
- FSM, length latch and output registers live in bram_write_ctrl.

Test Plan:
- Reset, then start_i with len_i=4, s_valid_i held high, data 0xA0..0xA3:
  - four consecutive cycles with bram_we_o=1, addr 0..3, matching data;
  - done_o one cycle, 2 cycles after the last handshake;
  - wr_cnt_o=4 at done_o.
- len_i=3 with s_valid_i toggling 1,0,0,1,0,1:
  - exactly 3 writes, addr 0,1,2;
  - no bram_we_o in the gap cycles;
  - single done_o pulse.
- len_i=0:
  - no bram_en_o assertion;
  - done_o 2 cycles after start_i;
  - wr_cnt_o=0.
- len_i=200 with DEPTH=128:
  - exactly 128 writes, addr 0..127, no wrap;
  - done_o once;
  - start_i pulses during WRITE ignored.
- Reset pulse mid-frame, after 2 of 5 writes:
  - all outputs 0 immediately;
  - no done_o;
  - a new start_i with len_i=2 writes addr 0,1.
- Back-to-back frames, second start_i in the done_o cycle:
  - second frame writes from addr 0;
  - two done_o pulses, no extra cycles dropped.
